// File: rtl/rvc_buffer.sv
// rvc_buffer: ready/valid FIFO with registered handshake outputs, a
// synchronous flush, an occupancy count and an almost_full flag.
// Storage is a register array that is read directly at the read pointer,
// so the head entry is visible on out_data with no extra latency.
module rvc_buffer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_almost_full;

  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;
  logic [CW-1:0]    w_count_next;

  // Handshakes use only registered flags, so no input reaches an output
  // combinationally.
  assign w_push  = in_valid & r_in_ready;
  assign w_pop   = r_out_valid & out_ready;
  assign w_wr_en = w_push & ~flush;

  // Next occupancy: flush wins over any concurrent push/pop.
  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Pointers, count and the registered status flags derived from next count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        // Power-of-two depth: pointers wrap naturally with no gap cycle.
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count       <= w_count_next;
      r_in_ready    <= (w_count_next < CW'(DEPTH));
      r_out_valid   <= (w_count_next != '0);
      r_almost_full <= (w_count_next >= CW'(AF_LEVEL));
    end
  end

  // Payload storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign out_data    = r_mem[r_rd_ptr];
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign count       = r_count;
  assign almost_full = r_almost_full;

endmodule

// File: tb/tb_rvc_buffer.sv
// Testbench for rvc_buffer: directed scenarios plus random traffic, checked
// against a queue-based model of FIFO behaviour.
module tb_rvc_buffer;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = DEPTH - 1;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic [CW-1:0]    count;
  logic             almost_full;

  int checks   = 0;
  int failures = 0;

  // Model state: stored entries in order, and whether an edge has occurred
  // since reset release (in_ready is low until the first such edge).
  logic [WIDTH-1:0] q[$];
  bit               m_rdy;

  rvc_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .count(count),
    .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    int n;
    n = q.size();
    chk({step, ".count"}, 64'(count), 64'(n));
    chk({step, ".out_valid"}, 64'(out_valid), 64'(n > 0));
    chk({step, ".in_ready"}, 64'(in_ready), 64'(m_rdy && n < DEPTH));
    chk({step, ".almost_full"}, 64'(almost_full), 64'(m_rdy && n >= AF_LEVEL));
    if (n > 0) chk({step, ".out_data"}, 64'(out_data), 64'(q[0]));
  endtask

  // Apply inputs, take one rising edge, update the model, check at negedge.
  task automatic drive_cycle(input string step, input logic iv, input logic [WIDTH-1:0] d,
                             input logic ordy, input logic fl);
    bit do_push, do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    do_push = iv && m_rdy && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    m_rdy = 1'b1;
    @(negedge clk);
    check_all(step);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    m_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset_hold");
    rst = 1'b1;

    // Reset release: in_ready rises one edge later, no push on that edge.
    drive_cycle("release", 1'b1, 8'h11, 1'b0, 1'b0);

    // Fill with A1..D4, no consumer.
    drive_cycle("fill0", 1'b1, 8'hA1, 1'b0, 1'b0);
    drive_cycle("fill1", 1'b1, 8'hB2, 1'b0, 1'b0);
    drive_cycle("fill2", 1'b1, 8'hC3, 1'b0, 1'b0);
    drive_cycle("fill3", 1'b1, 8'hD4, 1'b0, 1'b0);
    drive_cycle("full_hold", 1'b0, 8'h00, 1'b0, 1'b0);

    // Full: push and pop requested together, only the pop happens; the held
    // data goes in on the following edge.
    drive_cycle("full_pushpop", 1'b1, 8'hE5, 1'b1, 1'b0);
    drive_cycle("held_accept", 1'b1, 8'hE5, 1'b0, 1'b0);

    // Drain completely.
    for (int i = 0; i < DEPTH + 1; i++) drive_cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Steady state at count=2 across pointer wraps.
    drive_cycle("pre2_a", 1'b1, 8'h20, 1'b0, 1'b0);
    drive_cycle("pre2_b", 1'b1, 8'h21, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      drive_cycle("steady2", 1'b1, 8'(8'h22 + i), 1'b1, 1'b0);

    // Bring to count=3, then flush with a concurrent push.
    drive_cycle("pre3", 1'b1, 8'h40, 1'b0, 1'b0);
    drive_cycle("flush", 1'b1, 8'h77, 1'b0, 1'b1);
    drive_cycle("post_flush_a", 1'b1, 8'h50, 1'b0, 1'b0);
    drive_cycle("post_flush_b", 1'b0, 8'h00, 1'b1, 1'b0);
    drive_cycle("post_flush_c", 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      drive_cycle("random", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));

    // Mid-operation asynchronous reset at count=2.
    drive_cycle("pre_rst_flush", 1'b0, 8'h00, 1'b0, 1'b1);
    drive_cycle("pre_rst_a", 1'b1, 8'h61, 1'b0, 1'b0);
    drive_cycle("pre_rst_b", 1'b1, 8'h62, 1'b0, 1'b0);
    #1 rst = 1'b0;
    q.delete();
    m_rdy = 1'b0;
    #1 check_all("async_rst");
    #1 rst = 1'b1;
    drive_cycle("rst_release", 1'b1, 8'h5A, 1'b0, 1'b0);
    drive_cycle("rst_push_a", 1'b1, 8'h5A, 1'b0, 1'b0);
    drive_cycle("rst_push_b", 1'b1, 8'h6B, 1'b0, 1'b0);
    drive_cycle("rst_pop_a", 1'b0, 8'h00, 1'b1, 1'b0);
    drive_cycle("rst_pop_b", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
